// File: rtl/rgb_seq_ctrl_pkg.sv
// Shared types and default widths for the RGB LED sequencer.
// Used by rgb_seq_ctrl (top) and rgb_pwm3 (PWM back end).
package rgb_seq_pkg;

    // Default widths; the top-level parameters start from these values.
    localparam int DEF_DUTY_W = 8;
    localparam int DEF_HOLD_W = 16;

    // Sequencer states: idle, holding a colour, crossfading to the next one.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        FADE = 2'd2
    } seq_state_t;

    // One playlist entry at the default widths.
    typedef struct packed {
        logic [DEF_DUTY_W-1:0] red;
        logic [DEF_DUTY_W-1:0] green;
        logic [DEF_DUTY_W-1:0] blue;
        logic [DEF_HOLD_W-1:0] hold;
    } rgb_entry_t;

endpackage

// File: rtl/rgb_seq_ctrl_pwm3.sv
// Three-channel PWM generator for the RGB LED pins.
// One free-running counter (0 .. 2^DUTY_W-2) shared by three compares,
// so full-scale duty gives a constant 1 and zero duty a constant 0.
// Optional build macro RGB_SEQ_GAMMA_EN inserts a registered gamma stage
// g = (d*d + d) >> DUTY_W ahead of the compares (colour-to-pin latency 2
// instead of 1).
module rgb_pwm3
    import rgb_seq_pkg::*;
#(
    parameter int DUTY_W = DEF_DUTY_W
) (
    input  logic                   clk,
    input  logic                   rst,     // synchronous, active low
    input  logic [2:0][DUTY_W-1:0] duty,    // [2]=red [1]=green [0]=blue
    output logic [2:0]             pin
);

    // Last counter value; the period is 2^DUTY_W-1 so duty = all-ones is always on.
    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'((1 << DUTY_W) - 2);

    logic [DUTY_W-1:0] cnt_reg;

    // Free-running PWM counter shared by all three channels.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            logic [DUTY_W-1:0] eff_duty;
            logic              pin_reg;

`ifdef RGB_SEQ_GAMMA_EN
            logic [2*DUTY_W-1:0] d_ext;
            logic [DUTY_W-1:0]   gamma_reg;

            assign d_ext = {{DUTY_W{1'b0}}, duty[gi]};

            // Gamma approximation; d*d+d never exceeds 2*DUTY_W bits.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    gamma_reg <= '0;
                end else begin
                    gamma_reg <= DUTY_W'((d_ext * d_ext + d_ext) >> DUTY_W);
                end
            end

            assign eff_duty = gamma_reg;
`else
            assign eff_duty = duty[gi];
`endif

            // Registered compare drives the pin glitch-free.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    pin_reg <= 1'b0;
                end else begin
                    pin_reg <= (cnt_reg < eff_duty);
                end
            end

            assign pin[gi] = pin_reg;
        end
    endgenerate

endmodule

// File: rtl/rgb_seq_ctrl.sv
// RGB LED colour sequencer.
// Holds a small playlist (colour + hold time per entry) written through a
// valid/ready port while idle, then cycles through the first seq_len entries:
// hold each colour for (hold+1) step ticks, then fade linearly, one LSB per
// tick per channel, to the next entry. Pins are driven through rgb_pwm3.
// Optional build macro RGB_SEQ_GAMMA_EN enables the gamma stage in rgb_pwm3.
module rgb_seq_ctrl
    import rgb_seq_pkg::*;
#(
    parameter  int CLK_HZ      = 100000000,
    parameter  int STEP_HZ     = 1000,
    parameter  int NUM_ENTRIES = 8,
    parameter  int DUTY_W      = DEF_DUTY_W,
    parameter  int HOLD_W      = DEF_HOLD_W,
    localparam int AW          = $clog2(NUM_ENTRIES)
) (
    input  logic              clk100mhz,
    input  logic              rst,          // synchronous, active low
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [DUTY_W-1:0] cfg_red,
    input  logic [DUTY_W-1:0] cfg_green,
    input  logic [DUTY_W-1:0] cfg_blue,
    input  logic [HOLD_W-1:0] cfg_hold,
    input  logic [AW:0]       seq_len,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic [AW-1:0]     cur_idx,
    output logic              RGB1_Red,
    output logic              RGB1_Green,
    output logic              RGB1_Blue
);

    localparam int            DIV        = CLK_HZ / STEP_HZ;
    localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [AW:0]   MAX_LEN    = (AW + 1)'(NUM_ENTRIES);

    typedef struct packed {
        logic [DUTY_W-1:0] red;
        logic [DUTY_W-1:0] green;
        logic [DUTY_W-1:0] blue;
        logic [HOLD_W-1:0] hold;
    } entry_t;

    // Playlist storage (not reset).
    entry_t ram [NUM_ENTRIES];

    seq_state_t             state_reg;
    logic [AW-1:0]          cur_idx_reg;
    logic [AW:0]            len_reg;
    logic [HOLD_W-1:0]      hold_cnt_reg;
    logic [2:0][DUTY_W-1:0] col_reg;        // current colour, [2]=red
    logic [2:0][DUTY_W-1:0] tgt_reg;        // fade target colour
    logic [PW-1:0]          presc_reg;

    logic                   tick;
    logic                   start_ok;
    logic [AW-1:0]          nxt_idx;
    logic [AW-1:0]          rd_addr;
    entry_t                 rd_entry;
    logic [2:0][DUTY_W-1:0] rd_col;
    logic [2:0][DUTY_W-1:0] col_step;
    logic [2:0]             ch_done;
    logic [2:0]             pin;

    // ------------------------------------------------------------------
    // Playlist write/read
    // ------------------------------------------------------------------

    // Accept playlist writes only while idle.
    always_ff @(posedge clk100mhz) begin
        if (cfg_valid && cfg_ready) begin
            ram[cfg_addr] <= {cfg_red, cfg_green, cfg_blue, cfg_hold};
        end
    end

    // Successor entry wraps after the last active one. In FADE cur_idx has
    // not moved yet, so the same value addresses the fade target.
    assign nxt_idx = ({1'b0, cur_idx_reg} == (len_reg - 1'b1)) ? '0 : cur_idx_reg + 1'b1;

    // A single read port: entry 0 for a start, otherwise the successor.
    assign rd_addr  = (state_reg == IDLE) ? '0 : nxt_idx;
    assign rd_entry = ram[rd_addr];
    assign rd_col   = {rd_entry.red, rd_entry.green, rd_entry.blue};

    assign start_ok = start && (seq_len != '0) && (seq_len <= MAX_LEN);

    // ------------------------------------------------------------------
    // Step tick prescaler
    // ------------------------------------------------------------------

    // Count clocks between step ticks; parked at zero while idle.
    always_ff @(posedge clk100mhz) begin
        if (!rst || stop || state_reg == IDLE) begin
            presc_reg <= '0;
        end else if (presc_reg == PRESC_LAST) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    assign tick = (state_reg != IDLE) && (presc_reg == PRESC_LAST);

    // ------------------------------------------------------------------
    // Per-channel fade step
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_fade
            assign ch_done[gi]  = (col_reg[gi] == tgt_reg[gi]);
            assign col_step[gi] = (col_reg[gi] < tgt_reg[gi]) ? col_reg[gi] + 1'b1 :
                                  (col_reg[gi] > tgt_reg[gi]) ? col_reg[gi] - 1'b1 :
                                                                col_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------

    // Sequencer: stop beats everything, then start / hold countdown / fade.
    always_ff @(posedge clk100mhz) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cur_idx_reg  <= '0;
            len_reg      <= '0;
            hold_cnt_reg <= '0;
            col_reg      <= '0;
            tgt_reg      <= '0;
        end else if (stop) begin
            state_reg   <= IDLE;
            cur_idx_reg <= '0;
            col_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_ok) begin
                        len_reg      <= seq_len;
                        cur_idx_reg  <= '0;
                        col_reg      <= rd_col;
                        hold_cnt_reg <= rd_entry.hold;
                        state_reg    <= HOLD;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (hold_cnt_reg == '0) begin
                            tgt_reg   <= rd_col;
                            state_reg <= FADE;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg - 1'b1;
                        end
                    end
                end
                FADE: begin
                    if (tick) begin
                        if (&ch_done) begin
                            cur_idx_reg  <= nxt_idx;
                            hold_cnt_reg <= rd_entry.hold;
                            state_reg    <= HOLD;
                        end else begin
                            col_reg <= col_step;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign cfg_ready = (state_reg == IDLE);
    assign cur_idx   = cur_idx_reg;

    // ------------------------------------------------------------------
    // PWM back end
    // ------------------------------------------------------------------
    rgb_pwm3 #(
        .DUTY_W (DUTY_W)
    ) u_pwm (
        .clk  (clk100mhz),
        .rst  (rst),
        .duty (col_reg),
        .pin  (pin)
    );

    assign RGB1_Red   = pin[2];
    assign RGB1_Green = pin[1];
    assign RGB1_Blue  = pin[0];

endmodule

// File: tb/tb_rgb_seq_ctrl.sv
// Testbench for rgb_seq_ctrl: directed scenarios plus randomized playlists,
// with every cycle compared against a behavioural model of the sequencer.
// Honours RGB_SEQ_GAMMA_EN to match a gamma-enabled build.
`timescale 1ns/1ps
module tb_rgb_seq_ctrl;
    import rgb_seq_pkg::*;

    localparam int CLK_HZ  = 1000;
    localparam int STEP_HZ = 100;
    localparam int NE      = 8;
    localparam int AW      = 3;
    localparam int DW      = 8;
    localparam int HW      = 16;
    localparam int DIV     = CLK_HZ / STEP_HZ;
    localparam int PERIOD  = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_red, cfg_green, cfg_blue;
    logic [HW-1:0] cfg_hold;
    logic [AW:0]   seq_len;
    logic          start, stop;
    logic          busy;
    logic [AW-1:0] cur_idx;
    logic          RGB1_Red, RGB1_Green, RGB1_Blue;

    always #5 clk = ~clk;

    rgb_seq_ctrl #(
        .CLK_HZ      (CLK_HZ),
        .STEP_HZ     (STEP_HZ),
        .NUM_ENTRIES (NE),
        .DUTY_W      (DW),
        .HOLD_W      (HW)
    ) dut (
        .clk100mhz  (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_red    (cfg_red),
        .cfg_green  (cfg_green),
        .cfg_blue   (cfg_blue),
        .cfg_hold   (cfg_hold),
        .seq_len    (seq_len),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .cur_idx    (cur_idx),
        .RGB1_Red   (RGB1_Red),
        .RGB1_Green (RGB1_Green),
        .RGB1_Blue  (RGB1_Blue)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model: playlist array, colours as integers,
    // a cycle count since start for the tick, modulo for wrap-around.
    // ------------------------------------------------------------------
    rgb_entry_t m_ram [NE];
    bit  m_known   = 0;
    bit  m_busy    = 0;
    bit  m_fading  = 0;
    int  m_idx     = 0;
    int  m_len     = 1;
    int  m_hold    = 0;
    int  m_cyc     = 0;     // clocks since the sequence started, modulo DIV
    int  m_pwm     = 0;
    int  m_col [3] = '{0, 0, 0};   // 0=red 1=green 2=blue
    int  m_tgt [3] = '{0, 0, 0};
    int  m_gam [3] = '{0, 0, 0};
    bit  m_pin [3] = '{0, 0, 0};

    function automatic int gamma_of(input int d);
        return (d * d + d) >> DW;
    endfunction

    function automatic int duty_of(input int c);
`ifdef RGB_SEQ_GAMMA_EN
        return gamma_of(c);
`else
        return c;
`endif
    endfunction

    task automatic load_col(input int idx, output int col [3]);
        col[0] = int'(m_ram[idx].red);
        col[1] = int'(m_ram[idx].green);
        col[2] = int'(m_ram[idx].blue);
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_edge();
        bit was_idle;
        bit tick;
        int nx;
        was_idle = !m_busy;
        for (int c = 0; c < 3; c++) begin
`ifdef RGB_SEQ_GAMMA_EN
            m_pin[c] = (m_pwm < m_gam[c]);
            m_gam[c] = gamma_of(m_col[c]);
`else
            m_pin[c] = (m_pwm < m_col[c]);
`endif
        end
        m_pwm = (m_pwm + 1) % PERIOD;
        if (!rst) begin
            m_known = 1;
            m_busy  = 0;
            m_idx   = 0;
            m_pwm   = 0;
            m_cyc   = 0;
            for (int c = 0; c < 3; c++) begin
                m_col[c] = 0;
                m_gam[c] = 0;
                m_pin[c] = 0;
            end
        end else if (stop) begin
            m_busy = 0;
            m_idx  = 0;
            m_cyc  = 0;
            for (int c = 0; c < 3; c++) m_col[c] = 0;
        end else if (!m_busy) begin
            if (start && seq_len >= 1 && seq_len <= NE) begin
                m_busy   = 1;
                m_fading = 0;
                m_len    = int'(seq_len);
                m_idx    = 0;
                m_cyc    = 0;
                m_hold   = int'(m_ram[0].hold);
                load_col(0, m_col);
            end
        end else begin
            tick  = (m_cyc == DIV - 1);
            m_cyc = (m_cyc + 1) % DIV;
            if (tick) begin
                nx = (m_idx + 1) % m_len;
                if (!m_fading) begin
                    if (m_hold == 0) begin
                        m_fading = 1;
                        load_col(nx, m_tgt);
                    end else begin
                        m_hold--;
                    end
                end else if (m_col == m_tgt) begin
                    m_fading = 0;
                    m_idx    = nx;
                    m_hold   = int'(m_ram[nx].hold);
                end else begin
                    for (int c = 0; c < 3; c++) begin
                        if (m_tgt[c] > m_col[c]) m_col[c]++;
                        else if (m_tgt[c] < m_col[c]) m_col[c]--;
                    end
                end
            end
        end
        if (cfg_valid && was_idle) begin
            m_ram[cfg_addr] = {cfg_red, cfg_green, cfg_blue, cfg_hold};
        end
    endtask

    // One clock: update the model at the edge, compare outputs 1 ns later.
    task automatic step_cycle();
        @(posedge clk);
        model_edge();
        #1;
        if (m_known) begin
            check_val("pins", int'({RGB1_Red, RGB1_Green, RGB1_Blue}),
                      int'({m_pin[0], m_pin[1], m_pin[2]}));
            check_val("busy", int'(busy), int'(m_busy));
            check_val("cfg_ready", int'(cfg_ready), int'(!m_busy));
            check_val("cur_idx", int'(cur_idx), m_idx);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic write_entry(input int a, input int r, input int g, input int b, input int h);
        cfg_addr  = AW'(a);
        cfg_red   = DW'(r);
        cfg_green = DW'(g);
        cfg_blue  = DW'(b);
        cfg_hold  = HW'(h);
        cfg_valid = 1'b1;
        $display("[tb] write addr=%0d rgb=(%0d,%0d,%0d) hold=%0d ready=%0d", a, r, g, b, h, cfg_ready);
        step_cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic start_seq(input int len);
        seq_len = (AW + 1)'(len);
        start   = 1'b1;
        $display("[tb] start seq_len=%0d", len);
        step_cycle();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        $display("[tb] stop");
        step_cycle();
        stop = 1'b0;
    endtask

    // Count high cycles of each pin over one full PWM period.
    task automatic measure(output int hr, output int hg, output int hb);
        hr = 0; hg = 0; hb = 0;
        for (int i = 0; i < PERIOD; i++) begin
            step_cycle();
            hr += int'(RGB1_Red);
            hg += int'(RGB1_Green);
            hb += int'(RGB1_Blue);
        end
        $display("[tb] measure highs r=%0d g=%0d b=%0d", hr, hg, hb);
    endtask

    initial begin
        int hr, hg, hb;
        int len, n;

        // Reset with random inputs on the data/control lines.
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_addr  = AW'($urandom);
        cfg_red   = DW'($urandom);
        cfg_green = DW'($urandom);
        cfg_blue  = DW'($urandom);
        cfg_hold  = HW'($urandom);
        seq_len   = (AW + 1)'($urandom);
        start     = 1'($urandom);
        stop      = 1'($urandom);
        run(3);
        $display("[tb] reset done");
        check_val("rst_pins", int'({RGB1_Red, RGB1_Green, RGB1_Blue}), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_ready", int'(cfg_ready), 1);
        check_val("rst_idx", int'(cur_idx), 0);
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        step_cycle();

        // Fill the playlist so every entry is known to the model.
        for (int a = 0; a < NE; a++)
            write_entry(a, $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20),
                        $urandom_range(0, 3));

        // Single full-red entry loops forever.
        write_entry(0, 255, 0, 0, 2);
        start_seq(1);
        run(5);
        measure(hr, hg, hb);
        check_val("s2_red", hr, PERIOD);
        check_val("s2_green", hg, 0);
        check_val("s2_blue", hb, 0);
        run(100);
        check_val("s2_idx", int'(cur_idx), 0);
        check_val("s2_busy", int'(busy), 1);
        do_stop();

        // Two-entry fade 0 -> 4 -> 0.
        write_entry(0, 0, 0, 0, 0);
        write_entry(1, 4, 0, 0, 1);
        start_seq(2);
        run(69);
        check_val("s3_idx1", int'(cur_idx), 1);
        run(65);
        check_val("s3_idx0", int'(cur_idx), 0);
        do_stop();

        // Stop in the middle of a fade.
        start_seq(2);
        run(25);
        do_stop();
        check_val("s4_busy", int'(busy), 0);
        check_val("s4_ready", int'(cfg_ready), 1);
        step_cycle();
        check_val("s4_pins", int'({RGB1_Red, RGB1_Green, RGB1_Blue}), 0);

        // start together with stop: stop wins.
        stop = 1'b1;
        start_seq(2);
        stop = 1'b0;
        check_val("s4_start_stop", int'(busy), 0);

        // Illegal and boundary lengths.
        start_seq(0);
        check_val("s5_len0", int'(busy), 0);
        start_seq(NE + 1);
        check_val("s5_len9", int'(busy), 0);
        start_seq(NE);
        check_val("s5_len8", int'(busy), 1);
        do_stop();

        // Write while busy is refused; entry keeps its colour.
        write_entry(0, 40, 80, 160, 1000);
        start_seq(1);
        run(3);
        check_val("s5_ready_busy", int'(cfg_ready), 0);
        write_entry(0, 200, 10, 10, 5);
        do_stop();
        start_seq(1);
        run(5);
        measure(hr, hg, hb);
        check_val("s5_keep_r", hr, duty_of(40));
        check_val("s5_keep_g", hg, duty_of(80));
        check_val("s5_keep_b", hb, duty_of(160));
        do_stop();

        // Gamma reference colour.
        write_entry(0, 128, 255, 0, 1000);
        start_seq(1);
        run(5);
        measure(hr, hg, hb);
`ifdef RGB_SEQ_GAMMA_EN
        check_val("s6_red", hr, 64);
`else
        check_val("s6_red", hr, 128);
`endif
        check_val("s6_green", hg, 255);
        check_val("s6_blue", hb, 0);
        do_stop();

        // Randomized playlists, lengths and stops.
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++)
                write_entry($urandom_range(0, NE - 1), $urandom_range(0, 12),
                            $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 3));
            len = $urandom_range(0, NE + 1);
            start_seq(len);
            run($urandom_range(20, 300));
            if ($urandom_range(0, 3) == 0) begin
                start_seq($urandom_range(1, NE));
                run($urandom_range(5, 40));
            end
            if ($urandom_range(0, 1) == 1) begin
                cfg_valid = 1'b1;
                cfg_addr  = AW'($urandom);
                step_cycle();
                cfg_valid = 1'b0;
            end
            do_stop();
            run($urandom_range(1, 5));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
